// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg: shared FSM state type and default geometry for the systolic feeder
package systolic_feeder_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, WAIT, FIN} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_ROW = 4;
  localparam int DEF_COL = 4;
endpackage

// File: rtl/systolic_feeder_skew_gen.sv
// skew_gen: diagonal read-enable skew for the row FIFOs
// Ports: t (drain step counter) -> read (read[r] high while r <= t < r+COL)
module skew_gen
  import systolic_feeder_pkg::*;
#(
  parameter int ROW = DEF_ROW,
  parameter int COL = DEF_COL,
  parameter int TW = $clog2(DEF_ROW + DEF_COL)
) (
  input  logic [TW-1:0]  t,
  output logic [ROW-1:0] read
);
  for (genvar r = 0; r < ROW; r++) begin : g_row
    assign read[r] = int'(t) >= r && int'(t) < r + COL;
  end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: streams a ROW x COL operand tile into row FIFOs, then drains them skewed into the array
// Ports: clk, rst (async active-high); start begins a tile; in_valid/in_ready/in_w/in_i operand stream;
//        write/data_w/data_i per-row FIFO write strobes and data; read per-row FIFO read strobes;
//        cs array enable; array_done from the array; busy/done status; cycles performance count.
// Define FEEDER_PERF_CNT_EN to build the cycles counter; otherwise cycles is tied to 0.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROW = DEF_ROW,
  parameter int COL = DEF_COL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_w,
  input  logic [WIDTH-1:0] in_i,
  output logic [ROW-1:0]   write,
  output logic [ROW-1:0]   read,
  output logic [WIDTH-1:0] data_w,
  output logic [WIDTH-1:0] data_i,
  output logic             cs,
  input  logic             array_done,
  output logic             busy,
  output logic             done,
  output logic [31:0]      cycles
);
  localparam int KW = $clog2(ROW * COL);
  localparam int TW = $clog2(ROW + COL);
  localparam int LAST_K = ROW * COL - 1;
  localparam int LAST_T = ROW + COL - 2;
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [TW-1:0] t;
  logic [ROW-1:0] skew;
  logic hs;
  assign in_ready = state == LOAD;
  assign hs = in_valid & in_ready;
  assign busy = state != IDLE;
  assign cs = state == DRAIN || state == WAIT;
  assign done = state == FIN;
  assign read = state == DRAIN ? skew : '0;
  skew_gen #(.ROW(ROW), .COL(COL), .TW(TW)) u_skew (.t(t), .read(skew));
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? LOAD : IDLE;
      LOAD: state_n = hs && k == KW'(LAST_K) ? DRAIN : LOAD;
      DRAIN: state_n = t == TW'(LAST_T) ? WAIT : DRAIN;
      WAIT: state_n = array_done ? FIN : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      t <= '0;
      write <= '0;
      data_w <= '0;
      data_i <= '0;
    end else begin
      state <= state_n;
      k <= state == LOAD ? (hs ? k + 1'b1 : k) : '0;
      t <= state == DRAIN ? t + 1'b1 : '0;
      write <= hs ? ROW'(1) << (int'(k) / COL) : '0;
      if (hs) begin
        data_w <= in_w;
        data_i <= in_i;
      end
    end
  end
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] cnt;
  // the accepted start cycle is counted as the first cycle of the tile
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= state == IDLE ? (start ? 32'd1 : cnt) : cnt + 32'd1;
  end
  assign cycles = cnt;
`else
  assign cycles = '0;
`endif
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand bit width.
REQ-002 SHALL have parameter ROW, default 4, number of array rows and row FIFOs.
REQ-003 SHALL have parameter COL, default 4, array columns; also the depth of each row FIFO.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit, pulse that begins one tile operation.
REQ-007 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the operand-stream handshake.
REQ-008 SHALL have ports in_w and in_i, inputs, WIDTH bits each: the weight and input operand pair.
REQ-009 SHALL have ports write and read, outputs, ROW bits each: per-row FIFO strobes.
REQ-010 SHALL have ports data_w and data_i, outputs, WIDTH bits each: FIFO write data.
REQ-011 SHALL have port cs, output, 1 bit: array enable.
REQ-012 SHALL have port array_done, input, 1 bit: completion flag from the array.
REQ-013 SHALL have ports busy and done, outputs, 1 bit each: status and end-of-tile pulse.
REQ-014 SHALL have port cycles, output, 32 bits: performance count.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DRAIN, WAIT, FIN.
REQ-016 IDLE: start=1 -> LOAD; start in any other state is ignored.
REQ-017 LOAD: in_ready=1; a handshake (in_valid & in_ready) captures element k, k=0..ROW*COL-1.
- Element k goes to row r=k/COL.
REQ-018 One cycle after a handshake, write SHALL equal one-hot(r), and data_w/data_i SHALL hold the registered in_w/in_i; write is 0 otherwise.
REQ-019 After handshake k=ROW*COL-1 -> DRAIN; in_ready drops in the next cycle.
REQ-020 in_valid outside LOAD SHALL be ignored, and in_ready SHALL be 0 there.
REQ-021 DRAIN: a counter t runs 0..ROW+COL-2.
- read[r]=1 iff r <= t < r+COL (diagonal skew).
- cs=1 throughout.
- At t=ROW+COL-2 -> WAIT.
REQ-022 WAIT: cs=1, read=0; array_done=1 -> FIN; the flag is accepted even if it is already high on entry.
REQ-023 FIN: done=1 for exactly one cycle, cs=0, then -> IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Element and drain counters SHALL be sized clog2(ROW*COL) and clog2(ROW+COL) respectively; no wrap occurs within one tile.

Reset
REQ-026 Reset SHALL force state IDLE; counters 0; write, read, cs, in_ready, busy, done, cycles 0; data_w/data_i 0.
REQ-027 Reset asserted mid-operation SHALL abort the tile with no further strobes; partially filled FIFOs are the upstream controller's responsibility.

Configuration
REQ-028 With FEEDER_PERF_CNT_EN defined, cycles SHALL clear on start in IDLE, increment each cycle while busy, and hold its final value after FIN until the next start.
REQ-029 Without FEEDER_PERF_CNT_EN, cycles SHALL be constant 0 and no counter SHALL be synthesised.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the default WIDTH/ROW/COL constants.
REQ-031 The skew generator SHALL be a sub-module, skew_gen (inputs t; output read vector).

Verification
REQ-032 Defaults, 16 elements streamed back-to-back:
- write pulses 0001 x4, 0010 x4, 0100 x4, 1000 x4, each one cycle after its handshake.
REQ-033 The same load with in_valid toggling every other cycle:
- exactly 16 write pulses, with data order preserved.
REQ-034 DRAIN with defaults: read vectors over t=0..6 SHALL be
- 0001, 0011, 0111, 1111, 1110, 1100, 1000
- cs=1 over those 7 cycles.
REQ-035 array_done raised 5 cycles after WAIT entry:
- done pulses once in the following cycle, then busy=0.
- With FEEDER_PERF_CNT_EN, cycles = 1+16+7+6+1 = 31.
REQ-036 rst asserted at element 9 of LOAD:
- all outputs 0 immediately.
- A later start restarts at row 0.
REQ-037 start pulsed during DRAIN:
- no state change; the read sequence is unaltered.
